// File: rtl/mac_tile_dual_pkg.sv
// mac_tile_dual_pkg: instruction bit positions and dataflow mode encodings
package mac_tile_dual_pkg;
    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_SWAP  = 2;
    localparam int INST_DRAIN = 3;
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;
endpackage

// File: rtl/mac_tile_dual_dot.sv
// mac_dot: lanes-wide unsigned-activation x signed-weight dot product plus addend, wrapping at psum_bw
module mac_dot #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 1
) (
    input  logic [bw*lanes-1:0] a,
    input  logic [bw*lanes-1:0] w,
    input  logic [psum_bw-1:0]  addend,
    output logic [psum_bw-1:0]  y
);
    logic [psum_bw-1:0] prod [lanes];
    for (genvar i = 0; i < lanes; i++) begin : g_lane
        assign prod[i] = {{(psum_bw-bw){1'b0}}, a[i*bw +: bw]} * {{(psum_bw-bw){w[i*bw+bw-1]}}, w[i*bw +: bw]};
    end
    always_comb begin
        y = addend;
        for (int k = 0; k < lanes; k++) y = y + prod[k];
    end
endmodule

// File: rtl/mac_tile_dual.sv
// mac_tile_dual: double-buffered-weight systolic MAC tile, weight- or output-stationary
module mac_tile_dual
    import mac_tile_dual_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bw*lanes-1:0] in_w,
    output logic [bw*lanes-1:0] out_e,
    input  logic [3:0]          inst_w,
    output logic [3:0]          inst_e,
    input  logic [psum_bw-1:0]  in_n,
    output logic [psum_bw-1:0]  out_s,
    input  logic                os_mode
);
    logic [bw*lanes-1:0] a_q, e_q, w_sh, w_act;
    logic [psum_bw-1:0]  n_q, acc, s_q, ws_sum, os_sum;
    logic [3:0]          inst_q;
    logic                ready_q, mode_q;
    logic                load, exec, swap, drain;
    assign load  = inst_w[INST_LOAD];
    assign exec  = inst_w[INST_EXEC];
    assign swap  = inst_w[INST_SWAP];
    assign drain = inst_w[INST_DRAIN];
    mac_dot #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) u_ws (
        .a(a_q), .w(w_act), .addend(n_q), .y(ws_sum)
    );
    mac_dot #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) u_os (
        .a(in_w), .w(in_n[bw*lanes-1:0]), .addend(acc), .y(os_sum)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            e_q     <= '0;
            w_sh    <= '0;
            w_act   <= '0;
            n_q     <= '0;
            acc     <= '0;
            s_q     <= '0;
            inst_q  <= '0;
            ready_q <= 1'b1;
            mode_q  <= MODE_WS;
        end else begin
            if (inst_w == 4'd0) mode_q <= os_mode;
            if (load || exec || swap) e_q <= in_w;
            // a load is consumed by the first tile with an empty shadow bank
            inst_q <= {drain, swap, exec, load & ~ready_q};
            if (load && ready_q) w_sh <= in_w;
            if (swap) w_act <= w_sh;
            ready_q <= (load && ready_q) ? 1'b0 : (swap ? 1'b1 : ready_q);
            if (exec) begin
                a_q <= in_w;
                n_q <= in_n;
            end
            if (mode_q == MODE_OS) begin
                if (drain) begin
                    s_q <= acc;
                    acc <= in_n;
                end else if (exec) begin
                    s_q <= in_n;
                    acc <= os_sum;
                end
            end
        end
    end
    assign out_e  = e_q;
    assign inst_e = inst_q;
    assign out_s  = (mode_q == MODE_OS) ? s_q : ws_sum;
endmodule

// File: tb/tb_mac_tile_dual.sv
// tb_mac_tile_dual: directed table plus OS/mode sequences for a 2-lane tile
module tb_mac_tile_dual;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_w = '0;
    logic [7:0]  out_e;
    logic [3:0]  inst_w = '0;
    logic [3:0]  inst_e;
    logic [15:0] in_n = '0;
    logic [15:0] out_s;
    logic        os_mode = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    mac_tile_dual #(.bw(4), .psum_bw(16), .lanes(2)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e), .inst_w(inst_w),
        .inst_e(inst_e), .in_n(in_n), .out_s(out_s), .os_mode(os_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  inst;
        logic [7:0]  w;
        logic [15:0] n;
        logic [15:0] exp_s;
        logic [3:0]  exp_ie;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vec [16];

    task automatic step(input logic r, input logic [3:0] i, input logic [7:0] w, input logic [15:0] n, input logic m);
        @(negedge clk);
        reset = r; inst_w = i; in_w = w; in_n = n; os_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // weights {-2,3} = 8'h3E, activations {5,1} = 8'h15; lane 0 is the low nibble
        vec[0]  = '{1'b1, 4'h0, 8'h00, 16'd0,     16'd0,     4'h0, 8'h00};
        vec[1]  = '{1'b0, 4'h1, 8'h3E, 16'd0,     16'd0,     4'h0, 8'h3E};
        vec[2]  = '{1'b0, 4'h1, 8'h55, 16'd0,     16'd0,     4'h1, 8'h55};
        vec[3]  = '{1'b0, 4'h4, 8'h00, 16'd0,     16'd0,     4'h4, 8'h00};
        vec[4]  = '{1'b0, 4'h2, 8'h15, 16'd100,   16'd93,    4'h2, 8'h15};
        vec[5]  = '{1'b0, 4'h1, 8'h77, 16'd0,     16'd93,    4'h0, 8'h77};
        vec[6]  = '{1'b0, 4'h2, 8'h15, 16'd100,   16'd93,    4'h2, 8'h15};
        vec[7]  = '{1'b0, 4'h4, 8'h00, 16'd0,     16'd142,   4'h4, 8'h00};
        vec[8]  = '{1'b0, 4'h2, 8'h11, 16'd0,     16'd14,    4'h2, 8'h11};
        vec[9]  = '{1'b0, 4'h1, 8'h01, 16'd0,     16'd14,    4'h0, 8'h01};
        vec[10] = '{1'b0, 4'h6, 8'h0F, 16'd32767, 16'h800E,  4'h6, 8'h0F};
        vec[11] = '{1'b0, 4'h8, 8'h00, 16'd0,     16'h800E,  4'h8, 8'h0F};
        vec[12] = '{1'b1, 4'h2, 8'h15, 16'd9,     16'd0,     4'h0, 8'h00};
        vec[13] = '{1'b0, 4'h5, 8'h3E, 16'd0,     16'd0,     4'h4, 8'h3E};
        vec[14] = '{1'b0, 4'h4, 8'h00, 16'd0,     16'd0,     4'h4, 8'h00};
        vec[15] = '{1'b0, 4'h2, 8'h15, 16'd100,   16'd93,    4'h2, 8'h15};
        for (int i = 0; i < 16; i++) begin
            step(vec[i].rst, vec[i].inst, vec[i].w, vec[i].n, 1'b0);
            chk($sformatf("row%0d out_s", i), out_s, vec[i].exp_s);
            chk($sformatf("row%0d inst_e", i), {12'd0, inst_e}, {12'd0, vec[i].exp_ie});
            chk($sformatf("row%0d out_e", i), {8'd0, out_e}, {8'd0, vec[i].exp_oe});
        end
        step(1'b0, 4'h2, 8'h00, 16'd0, 1'b1);
        chk("mode held during exec", {15'd0, dut.mode_q}, 16'd0);
        step(1'b0, 4'h0, 8'h00, 16'd0, 1'b1);
        chk("mode taken when idle", {15'd0, dut.mode_q}, 16'd1);
        chk("acc clear before os", dut.acc, 16'd0);
        // a={15,15}, weights {-8,-8} on in_n low byte: -240 per cycle
        step(1'b0, 4'h2, 8'hFF, 16'h0088, 1'b1);
        chk("os weights passed south", out_s, 16'h0088);
        chk("os acc after 1", dut.acc, 16'hFF10);
        step(1'b0, 4'h2, 8'hFF, 16'h0088, 1'b1);
        step(1'b0, 4'h2, 8'hFF, 16'h0088, 1'b1);
        chk("os acc after 3", dut.acc, 16'hFD30);
        step(1'b0, 4'h8, 8'h00, 16'd5, 1'b1);
        chk("os drain out_s", out_s, 16'hFD30);
        chk("os drain acc", dut.acc, 16'd5);
        chk("os drain inst_e", {12'd0, inst_e}, 16'h0008);
        step(1'b0, 4'hA, 8'hFF, 16'd7, 1'b1);
        chk("os exec+drain out_s", out_s, 16'd5);
        chk("os exec+drain acc", dut.acc, 16'd7);
        chk("os exec+drain inst_e", {12'd0, inst_e}, 16'h000A);
        step(1'b1, 4'h2, 8'hFF, 16'h0088, 1'b1);
        chk("reset out_s", out_s, 16'd0);
        chk("reset acc", dut.acc, 16'd0);
        chk("reset mode", {15'd0, dut.mode_q}, 16'd0);
        chk("reset ready", {15'd0, dut.ready_q}, 16'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_tile_dual.md
# mac_tile_dual

Parametrised successor to the single-lane systolic MAC tile. It computes a `lanes`-wide dot product per cycle and double-buffers its weights, so a new kernel can be loaded while the current one is executing. It runs either weight-stationary (psum flows north to south) or output-stationary (accumulates locally, then drains south as a shift chain). The tile is instantiated in a rows x cols grid by the systolic array top; activations and instructions flow west to east.

## Interface
- `bw`, 4, element width (activations unsigned, weights signed two's complement)
- `psum_bw`, 16, psum/accumulator width (signed)
- `lanes`, 1, elements per cycle; dot-product length
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_w`  in  bw*lanes  activations (execute) or weights (load); lane i = bits [i*bw +: bw]
- `out_e`  out  bw*lanes  registered `in_w` to east neighbour
- `inst_w`  in  4  [0] load, [1] execute, [2] swap, [3] drain
- `inst_e`  out  4  registered instruction to east neighbour
- `in_n`  in  psum_bw  WS: incoming psum; OS: weights in low bw*lanes bits (execute) or upstream accumulator (drain)
- `out_s`  out  psum_bw  WS: psum result; OS: weights passed south or drained accumulator
- `os_mode`  in  1  0 = weight-stationary, 1 = output-stationary

## Operation
- Registers: `a_q`, `n_q`, `w_sh` (shadow weights), `w_act` (active weights), `acc`, `s_q`, `inst_q`, `ready_q`, `mode_q`.
- Reset: all registers 0, except `ready_q` = 1. Consequently `out_e`=0, `inst_e`=0, `out_s`=0 and `mode_q`=0.
- `mode_q` <= `os_mode` only when `inst_w` == 0. A mode change while any instruction bit is set is ignored.
- Load (`inst_w[0]`):
  - If `ready_q`=1: `w_sh` <= `in_w`, `ready_q` <= 0, and `inst_e[0]` <= 0 (the load is consumed here).
  - If `ready_q`=0: `inst_e[0]` <= 1 (forwarded east).
- Swap (`inst_w[2]`): `w_act` <= `w_sh`, `ready_q` <= 1. Always forwarded: `inst_e[2]` <= 1.
- Load+swap in the same cycle: `w_act` gets the old `w_sh`; if `ready_q` was 1, `w_sh` also captures `in_w` and `ready_q` ends at 0.
- Execute (`inst_w[1]`): `a_q` <= `in_w`, `n_q` <= `in_n`. Always forwarded: `inst_e[1]` <= 1.
  - WS: `out_s` = `n_q` + sum over lanes of `a_q[i]` * `w_act[i]` (combinational from registers).
  - OS: `acc` <= `acc` + sum over lanes of `in_w[i]` * `in_n` lane i (signed); `s_q` <= `in_n`; `out_s` = `s_q`.
- Drain (`inst_w[3]`, OS only): `s_q` <= `acc`, `acc` <= `in_n`. Always forwarded. In WS mode drain is a no-op but is still forwarded.
- Execute+drain in the same cycle in OS: drain wins and execute is ignored, but both bits are forwarded.
- `out_e` <= `in_w` whenever any of load, execute or swap is set; otherwise it holds.
- Arithmetic: activation is zero-extended and weight sign-extended before multiply. Products and sums are computed in psum_bw two's complement and wrap on overflow (no saturation).

## Timing
- `in_w` / `inst_w` to `out_e` / `inst_e`: 1 cycle.
- WS: `in_n` to `out_s`: 1 cycle (registered inputs, combinational MAC).
- OS: weights pass `in_n` to `out_s` in 1 cycle. The first drained value appears 1 cycle after the first drain cycle. A column of R tiles needs R consecutive drain cycles.
- Swap takes effect at the edge it is sampled, so an activation captured on that same edge multiplies the new weights.
- Reset mid-operation clears accumulators and both weight banks. Weights must be reloaded after reset.

## Structure
- Shared package: instruction bit index constants (`INST_LOAD`, `INST_EXEC`, `INST_SWAP`, `INST_DRAIN`) and mode encodings.
- One sub-module, `mac_dot`: a combinational `lanes`-wide signed dot product plus addend, parametrised by `bw`, `psum_bw` and `lanes`. It is used for both the WS output and the OS accumulate.

## Test plan
All scenarios use `lanes`=2, `bw`=4, `psum_bw`=16.
- Reset, then load `in_w`={-2,3}, swap, then execute a={5,1}, `in_n`=100 (WS) -> `out_s`=93 the next cycle; `inst_e[0]`=0 on the load cycle.
- Second load while `ready_q`=0 -> `inst_e[0]`=1 one cycle later, and local `w_sh` unchanged.
- Load new {7,7} during WS execution without swap -> outputs still use {-2,3}; after swap, a={1,1}, `in_n`=0 gives `out_s`=14.
- OS with a={15,15} and weights {-8,-8} streamed for 3 cycles -> `acc`=-720; drain with `in_n`=5 gives `out_s`=-720, and `acc`=5.
- Drive `os_mode`=1 while execute is asserted -> `mode_q` stays 0; then idle 1 cycle -> `mode_q`=1.
- Overflow: `in_n`=32767 plus product 15 in WS -> `out_s`=-32754 (wrap). Then reset mid-stream -> all outputs 0 the next cycle.
